stream_uart_emitter: RTL and testbench

STREAM_UART_EMITTER -- requirements
Module: stream_uart_emitter

---
 rtl/stream_uart_emitter.sv | 190 +++++++++++++++++++
 tb/tb_stream_uart_emitter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_uart_emitter.sv
// Stream-to-UART emitter: buffers {tlast,tdata} in a small FIFO and serialises
// each byte as a UART frame. An optional end-of-packet character follows every
// byte tagged tlast.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high; pick pending EOP char or FIFO head, or wait
// S_START | start bit (low) for DIV clocks
// S_DATA  | 8 data bits, LSB first, DIV clocks each
// S_PAR   | parity bit for DIV clocks (never entered when PARITY=0)
// S_STOP  | line high for STOP_BITS*DIV clocks, then back to S_IDLE
module stream_uart_emitter #(
  parameter int         CLK_FREQ_HZ = 16000000,
  parameter int         BAUD        = 57600,
  parameter int         DEPTH       = 16,
  parameter int         PARITY      = 0,
  parameter int         STOP_BITS   = 1,
  parameter int         EOP_EN      = 1,
  parameter logic [7:0] EOP_CHAR    = 8'h0A
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_tdata,
  input  logic                     i_tlast,
  input  logic                     i_tvalid,
  output logic                     o_tready,
  output logic                     o_uart_tx,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_M1 = CW'(STOP_BITS * DIV - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam bit            ODD_PAR = (PARITY == 1);
  localparam bit            PAR_ON  = (PARITY != 0);
  localparam bit            EOP_ON  = (EOP_EN != 0);

  if (DIV < 2) begin : g_bad_div
    $error("stream_uart_emitter: CLK_FREQ_HZ/BAUD must round to at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_uart_emitter: DEPTH must be a power of two >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("stream_uart_emitter: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("stream_uart_emitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          tready_q;
  logic          push, pop;
  logic [8:0]    head;

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;
  logic          eop_pend_q;
  logic [7:0]    load_byte;

  assign push = i_tvalid & tready_q;
  // Pop only when the FSM is about to start a frame from the FIFO; a pending
  // EOP always wins so it lands directly after its tagged byte.
  assign pop  = (state_q == S_IDLE) && !eop_pend_q && (level_q != '0);
  assign head = mem_q[rd_ptr_q];
  assign load_byte = eop_pend_q ? EOP_CHAR : head[7:0];

  // Occupancy next-state: push and pop in the same cycle cancel out.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_tlast, i_tdata};
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      tready_q <= (level_d < DEPTH_L);
    end
  end

  // Transmit FSM; the line is a register so it never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      eop_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (eop_pend_q || pop) begin
            shift_q    <= load_byte;
            par_q      <= (^load_byte) ^ ODD_PAR;
            eop_pend_q <= eop_pend_q ? 1'b0 : (EOP_ON & head[8]);
            baud_q     <= DIV_M1;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            baud_q  <= DIV_M1;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
          end else if (bit_q != 3'd7) begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
            baud_q  <= DIV_M1;
          end else if (PAR_ON) begin
            tx_q    <= par_q;
            baud_q  <= DIV_M1;
            state_q <= S_PAR;
          end else begin
            tx_q    <= 1'b1;
            baud_q  <= STOP_M1;
            state_q <= S_STOP;
          end
        end
        S_PAR: begin
          if (baud_q == '0) begin
            tx_q    <= 1'b1;
            baud_q  <= STOP_M1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_q == '0) state_q <= S_IDLE;
          else              baud_q  <= baud_q - 1'b1;
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tready  = tready_q;
  assign o_uart_tx = tx_q;
  assign o_level   = level_q;
  assign o_busy    = (state_q != S_IDLE) || (level_q != '0) || eop_pend_q;

endmodule

// File: tb/tb_stream_uart_emitter.sv
// Bench for stream_uart_emitter: three instances (defaults, even parity with
// two stop bits, EOP disabled) at DIV=4, DEPTH=4. A line monitor per instance
// decodes frames and compares them against a queue of expected bytes.
module tb_stream_uart_emitter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tdata [3];
  logic       tlast [3];
  logic       tvalid[3];
  logic       tready[3];
  logic       tx    [3];
  logic       busy  [3];
  logic [2:0] level [3];

  int par_m [3] = '{0, 2, 0};
  int sb    [3] = '{1, 2, 1};
  int eop_en[3] = '{1, 1, 0};

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_start[3] = '{-1, -1, -1};
  logic last_par[3];
  int starts0[$];
  logic [7:0] exp0[$], exp1[$], exp2[$];
  int maxlvl = 0;
  int bad_rdy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_uart_emitter #(.CLK_FREQ_HZ(400), .BAUD(100), .DEPTH(4), .PARITY(0),
                        .STOP_BITS(1), .EOP_EN(1), .EOP_CHAR(8'h0A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[0]), .i_tlast(tlast[0]),
    .i_tvalid(tvalid[0]), .o_tready(tready[0]), .o_uart_tx(tx[0]),
    .o_busy(busy[0]), .o_level(level[0]));

  stream_uart_emitter #(.CLK_FREQ_HZ(400), .BAUD(100), .DEPTH(4), .PARITY(2),
                        .STOP_BITS(2), .EOP_EN(1), .EOP_CHAR(8'h0A)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[1]), .i_tlast(tlast[1]),
    .i_tvalid(tvalid[1]), .o_tready(tready[1]), .o_uart_tx(tx[1]),
    .o_busy(busy[1]), .o_level(level[1]));

  stream_uart_emitter #(.CLK_FREQ_HZ(400), .BAUD(100), .DEPTH(4), .PARITY(0),
                        .STOP_BITS(1), .EOP_EN(0), .EOP_CHAR(8'h0A)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[2]), .i_tlast(tlast[2]),
    .i_tvalid(tvalid[2]), .o_tready(tready[2]), .o_uart_tx(tx[2]),
    .o_busy(busy[2]), .o_level(level[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic get_tx(input int k);
    return tx[k];
  endfunction

  function automatic void exp_push(input int k, input logic [7:0] v);
    case (k)
      0: exp0.push_back(v);
      1: exp1.push_back(v);
      default: exp2.push_back(v);
    endcase
  endfunction

  // Returns 9'h100 when nothing is expected so any frame then mismatches.
  function automatic logic [8:0] exp_pop(input int k);
    logic [8:0] r;
    r = 9'h100;
    case (k)
      0: if (exp0.size() != 0) r = {1'b0, exp0.pop_front()};
      1: if (exp1.size() != 0) r = {1'b0, exp1.pop_front()};
      default: if (exp2.size() != 0) r = {1'b0, exp2.pop_front()};
    endcase
    return r;
  endfunction

  function automatic int exp_size(input int k);
    case (k)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  // Decode one frame per start bit, requiring every bit to hold for DIV clocks.
  task automatic monitor(input int k);
    logic [7:0] d;
    logic ok, ab, v, e, pv;
    logic [8:0] ev;
    int s, p, nb;
    p  = (par_m[k] != 0) ? 1 : 0;
    nb = 9 + p + sb[k];
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && get_tx(k) === 1'b0) begin
        s = cyc;
        last_start[k] = s;
        if (k == 0) starts0.push_back(s);
        ok = 1'b1; ab = 1'b0; d = '0; pv = 1'b0;
        for (int b = 0; b < nb && !ab; b++) begin
          for (int j = 0; j < DIV && !ab; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              ab = 1'b1;
            end else begin
              v = get_tx(k);
              if (b >= 1 && b <= 8) begin
                if (j == 0) d[b-1] = v;
                else if (v !== d[b-1]) ok = 1'b0;
              end else if (p == 1 && b == 9) begin
                e = (par_m[k] == 1) ? ~^d : ^d;
                if (j == 0) pv = v;
                if (v !== e) ok = 1'b0;
              end else begin
                e = (b == 0) ? 1'b0 : 1'b1;
                if (v !== e) ok = 1'b0;
              end
            end
          end
        end
        if (!ab) begin
          last_par[k] = pv;
          check_eq($sformatf("framing_k%0d", k), {31'd0, ok}, 32'd1);
          ev = exp_pop(k);
          check_eq($sformatf("rx_byte_k%0d", k), {24'd0, d}, {23'd0, ev});
        end
      end
    end
  endtask

  // Full-FIFO behaviour of the default instance, observed continuously.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (int'(level[0]) > maxlvl) maxlvl = int'(level[0]);
      if (level[0] == 3'd4 && tready[0] !== 1'b0) bad_rdy++;
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input int k, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    tdata[k] = d; tlast[k] = l; tvalid[k] = 1'b1;
    while (tready[k] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check_eq("push_timeout", {31'd0, tready[k]}, 32'd1);
    end else begin
      @(posedge clk);
      exp_push(k, d);
      if (l && eop_en[k] != 0) exp_push(k, 8'h0A);
    end
    @(negedge clk);
  endtask

  task automatic drop(input int k);
    tvalid[k] = 1'b0;
    tlast[k]  = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int bound, output int len);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[k] !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check_eq($sformatf("idle_timeout_k%0d", k), {31'd0, busy[k]}, 32'd0);
    len = cyc - last_start[k];
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n;
    for (int k = 0; k < 3; k++) begin
      tdata[k] = '0; tlast[k] = 1'b0; tvalid[k] = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx",     {31'd0, tx[0]},     32'd1);
    check_eq("rst_tready", {31'd0, tready[0]}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy[0]},   32'd0);
    check_eq("rst_level",  {29'd0, level[0]},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("tready_after_rst", {31'd0, tready[0]}, 32'd1);

    // Single byte, no tlast: one frame, busy drops 10*DIV clocks after start.
    push(0, 8'h55, 1'b0);
    drop(0);
    wait_idle(0, 200, len);
    check_eq("len_0x55", len, 40);

    // tlast byte followed by another: EOP slots in between, 41-clock spacing.
    starts0.delete();
    push(0, 8'h41, 1'b1);
    push(0, 8'h42, 1'b0);
    drop(0);
    wait_idle(0, 400, len);
    check_eq("start_count", starts0.size(), 3);
    if (starts0.size() >= 3) begin
      check_eq("spacing_1", starts0[1] - starts0[0], 41);
      check_eq("spacing_2", starts0[2] - starts0[1], 41);
    end

    // Even parity, two stop bits: 48-clock frame, parity bit of 0x07 is 1.
    push(1, 8'h07, 1'b0);
    drop(1);
    wait_idle(1, 200, len);
    check_eq("len_par_stop2", len, 48);
    check_eq("par_bit_0x07", {31'd0, last_par[1]}, 32'd1);

    // Six bytes with valid held high: FIFO fills, upstream stalls, nothing lost.
    for (int i = 0; i < 6; i++) push(0, 8'h10 + 8'(i), 1'b0);
    drop(0);
    wait_idle(0, 2000, len);

    // Reset in the middle of a data bit with three bytes queued.
    last_start[0] = -1;
    for (int i = 0; i < 4; i++) push(0, 8'h00, 1'b0);
    drop(0);
    n = 0;
    while (last_start[0] < 0 && n < 200) begin @(negedge clk); n++; end
    while (cyc < last_start[0] + 8 && n < 200) begin @(negedge clk); n++; end
    check_eq("pre_rst_tx", {31'd0, tx[0]}, 32'd0);
    check_eq("pre_rst_level", {29'd0, level[0]}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx",     {31'd0, tx[0]},     32'd1);
    check_eq("mid_rst_level",  {29'd0, level[0]},  32'd0);
    check_eq("mid_rst_tready", {31'd0, tready[0]}, 32'd0);
    check_eq("mid_rst_busy",   {31'd0, busy[0]},   32'd0);
    exp0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("tready_after_mid_rst", {31'd0, tready[0]}, 32'd1);
    repeat (100) @(negedge clk);
    check_eq("post_rst_busy", {31'd0, busy[0]}, 32'd0);
    check_eq("post_rst_tx",   {31'd0, tx[0]},   32'd1);
    push(0, 8'hA5, 1'b0);
    drop(0);
    wait_idle(0, 200, len);
    check_eq("len_after_rst", len, 40);

    // EOP disabled; a push lands on the same edge as a pop at level 2.
    last_start[2] = -1;
    push(2, 8'h31, 1'b1);
    push(2, 8'h32, 1'b0);
    push(2, 8'h33, 1'b0);
    drop(2);
    n = 0;
    while (last_start[2] < 0 && n < 200) begin @(negedge clk); n++; end
    while (cyc < last_start[2] + 40 && n < 200) begin @(negedge clk); n++; end
    check_eq("level_before_simul", {29'd0, level[2]}, 32'd2);
    push(2, 8'h34, 1'b0);
    check_eq("level_simul", {29'd0, level[2]}, 32'd2);
    drop(2);
    wait_idle(2, 600, len);

    repeat (10) @(negedge clk);
    check_eq("exp_left_a", exp_size(0), 0);
    check_eq("exp_left_b", exp_size(1), 0);
    check_eq("exp_left_c", exp_size(2), 0);
    check_eq("max_level", maxlvl, 4);
    check_eq("tready_at_full", bad_rdy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
